// File: rtl/alarm_controller_if.sv
// rtl/alarm_controller_if.sv - sensor, timer and indicator signals of the alarm sequencer
interface alarm_controller_if;
    logic       ignition;
    logic       door_driver;
    logic       door_pass;
    logic       expired;
    logic       half_hz_enable;
    logic [1:0] interval;
    logic       start_timer;
    logic       siren;
    logic       status;
    logic [2:0] state;

    modport master (
        input  ignition,
        input  door_driver,
        input  door_pass,
        input  expired,
        input  half_hz_enable,
        output interval,
        output start_timer,
        output siren,
        output status,
        output state
    );

    modport slave (
        output ignition,
        output door_driver,
        output door_pass,
        output expired,
        output half_hz_enable,
        input  interval,
        input  start_timer,
        input  siren,
        input  status,
        input  state
    );
endinterface

// File: rtl/alarm_controller.sv
// rtl/alarm_controller.sv - anti-theft sequencing FSM driving the countdown timer
module alarm_controller (
    input  logic               clock,
    input  logic               reset,
    alarm_controller_if.master bus
);
    typedef enum logic [2:0] {
        ARMED          = 3'b000,
        TRIGGERED      = 3'b001,
        ALARM_OPEN     = 3'b010,
        ALARM_HOLD     = 3'b011,
        DIS_IGN_ON     = 3'b100,
        DIS_WAIT_OPEN  = 3'b101,
        DIS_WAIT_CLOSE = 3'b110,
        DIS_ARM_DELAY  = 3'b111
    } state_t;

    localparam logic [1:0] T_ARM_DELAY       = 2'b00;
    localparam logic [1:0] T_DRIVER_DELAY    = 2'b01;
    localparam logic [1:0] T_PASSENGER_DELAY = 2'b10;
    localparam logic [1:0] T_ALARM_ON        = 2'b11;

    state_t     state_q;
    logic [1:0] interval_q;
    logic       start_q;
    logic       siren_q;
    logic       status_q;
    logic       door_any;
    logic       expired_ok;

    // The timer reloads on the edge after a start pulse, so a stale expired
    // seen while start_timer is high belongs to the previous countdown.
    assign door_any   = bus.door_driver | bus.door_pass;
    assign expired_ok = bus.expired & ~start_q;

    assign bus.state       = state_q;
    assign bus.interval    = interval_q;
    assign bus.start_timer = start_q;
    assign bus.siren       = siren_q;
    assign bus.status      = status_q;

    // State and all registered outputs advance together on each edge.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= ARMED;
            interval_q <= T_ARM_DELAY;
            start_q    <= 1'b0;
            siren_q    <= 1'b0;
            status_q   <= 1'b0;
        end else begin
            start_q <= 1'b0;
            if (bus.ignition) begin
                state_q  <= DIS_IGN_ON;
                siren_q  <= 1'b0;
                status_q <= 1'b0;
            end else begin
                case (state_q)
                    ARMED: begin
                        if (bus.door_driver) begin
                            state_q    <= TRIGGERED;
                            interval_q <= T_DRIVER_DELAY;
                            start_q    <= 1'b1;
                            status_q   <= 1'b1;
                        end else if (bus.door_pass) begin
                            state_q    <= TRIGGERED;
                            interval_q <= T_PASSENGER_DELAY;
                            start_q    <= 1'b1;
                            status_q   <= 1'b1;
                        end else if (bus.half_hz_enable) begin
                            status_q <= ~status_q;
                        end
                    end
                    TRIGGERED: begin
                        if (expired_ok) begin
                            state_q  <= ALARM_OPEN;
                            siren_q  <= 1'b1;
                            status_q <= 1'b1;
                        end
                    end
                    ALARM_OPEN: begin
                        if (!door_any) begin
                            state_q    <= ALARM_HOLD;
                            interval_q <= T_ALARM_ON;
                            start_q    <= 1'b1;
                        end
                    end
                    ALARM_HOLD: begin
                        // A reopened door abandons the hold countdown even if it expires now.
                        if (door_any) begin
                            state_q <= ALARM_OPEN;
                        end else if (expired_ok) begin
                            state_q  <= ARMED;
                            siren_q  <= 1'b0;
                            status_q <= 1'b0;
                        end
                    end
                    DIS_IGN_ON: begin
                        state_q <= DIS_WAIT_OPEN;
                    end
                    DIS_WAIT_OPEN: begin
                        if (bus.door_driver) begin
                            state_q <= DIS_WAIT_CLOSE;
                        end
                    end
                    DIS_WAIT_CLOSE: begin
                        if (!door_any) begin
                            state_q    <= DIS_ARM_DELAY;
                            interval_q <= T_ARM_DELAY;
                            start_q    <= 1'b1;
                        end
                    end
                    DIS_ARM_DELAY: begin
                        if (door_any) begin
                            state_q <= DIS_WAIT_CLOSE;
                        end else if (expired_ok) begin
                            state_q  <= ARMED;
                            status_q <= 1'b0;
                        end
                    end
                    default: begin
                        state_q <= ARMED;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_alarm_controller.sv
// tb/tb_alarm_controller.sv - directed self-checking bench for alarm_controller
module tb_alarm_controller;
    logic clock;
    logic reset;
    int   n_checks;
    int   n_fail;

    alarm_controller_if ifc ();

    alarm_controller dut (
        .clock (clock),
        .reset (reset),
        .bus   (ifc.master)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #1;
        n_checks++; if (ifc.state !== 3'd0) begin n_fail++; $display("FAIL rst_state: got %0d want 0", ifc.state); end
        n_checks++; if (ifc.siren !== 1'b0) begin n_fail++; $display("FAIL rst_siren: got %b want 0", ifc.siren); end
        n_checks++; if (ifc.status !== 1'b0) begin n_fail++; $display("FAIL rst_status: got %b want 0", ifc.status); end
        n_checks++; if (ifc.interval !== 2'd0) begin n_fail++; $display("FAIL rst_interval: got %0d want 0", ifc.interval); end
        n_checks++; if (ifc.start_timer !== 1'b0) begin n_fail++; $display("FAIL rst_start: got %b want 0", ifc.start_timer); end
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic test_armed_blink();
        logic exp_status;
        exp_status = 1'b0;
        for (int p = 0; p < 3; p++) begin
            ifc.half_hz_enable = 1'b1;
            step();
            ifc.half_hz_enable = 1'b0;
            exp_status = ~exp_status;
            n_checks++; if (ifc.status !== exp_status) begin n_fail++; $display("FAIL blink_status%0d: got %b want %b", p, ifc.status, exp_status); end
            step();
            n_checks++; if (ifc.status !== exp_status) begin n_fail++; $display("FAIL blink_hold%0d: got %b want %b", p, ifc.status, exp_status); end
            n_checks++; if (ifc.state !== 3'd0) begin n_fail++; $display("FAIL blink_state%0d: got %0d want 0", p, ifc.state); end
            n_checks++; if (ifc.start_timer !== 1'b0 || ifc.siren !== 1'b0) begin n_fail++; $display("FAIL blink_quiet%0d: got start=%b siren=%b want 0 0", p, ifc.start_timer, ifc.siren); end
        end
    endtask

    task automatic test_passenger_trigger();
        ifc.door_pass = 1'b1;
        step();
        ifc.door_pass = 1'b0;
        n_checks++; if (ifc.state !== 3'd1) begin n_fail++; $display("FAIL ptrig_state: got %0d want 1", ifc.state); end
        n_checks++; if (ifc.interval !== 2'd2) begin n_fail++; $display("FAIL ptrig_interval: got %0d want 2", ifc.interval); end
        n_checks++; if (ifc.start_timer !== 1'b1) begin n_fail++; $display("FAIL ptrig_start: got %b want 1", ifc.start_timer); end
        n_checks++; if (ifc.status !== 1'b1) begin n_fail++; $display("FAIL ptrig_status: got %b want 1", ifc.status); end
        ifc.expired = 1'b1;
        step();
        n_checks++; if (ifc.state !== 3'd1) begin n_fail++; $display("FAIL ptrig_stale_expired: got %0d want 1", ifc.state); end
        n_checks++; if (ifc.start_timer !== 1'b0) begin n_fail++; $display("FAIL ptrig_single_pulse: got %b want 0", ifc.start_timer); end
        step();
        ifc.expired = 1'b0;
        n_checks++; if (ifc.state !== 3'd2) begin n_fail++; $display("FAIL ptrig_open_state: got %0d want 2", ifc.state); end
        n_checks++; if (ifc.siren !== 1'b1) begin n_fail++; $display("FAIL ptrig_siren: got %b want 1", ifc.siren); end
    endtask

    task automatic test_alarm_hold();
        step();
        n_checks++; if (ifc.state !== 3'd3) begin n_fail++; $display("FAIL hold_state: got %0d want 3", ifc.state); end
        n_checks++; if (ifc.interval !== 2'd3) begin n_fail++; $display("FAIL hold_interval: got %0d want 3", ifc.interval); end
        n_checks++; if (ifc.start_timer !== 1'b1) begin n_fail++; $display("FAIL hold_start: got %b want 1", ifc.start_timer); end
        step();
        n_checks++; if (ifc.start_timer !== 1'b0) begin n_fail++; $display("FAIL hold_start_off: got %b want 0", ifc.start_timer); end
        ifc.door_driver = 1'b1;
        step();
        ifc.door_driver = 1'b0;
        n_checks++; if (ifc.state !== 3'd2) begin n_fail++; $display("FAIL hold_reopen: got %0d want 2", ifc.state); end
        step();
        n_checks++; if (ifc.state !== 3'd3 || ifc.start_timer !== 1'b1) begin n_fail++; $display("FAIL hold_restart: got state=%0d start=%b want 3 1", ifc.state, ifc.start_timer); end
        step();
        ifc.door_pass = 1'b1;
        ifc.expired = 1'b1;
        step();
        ifc.door_pass = 1'b0;
        ifc.expired = 1'b0;
        n_checks++; if (ifc.state !== 3'd2) begin n_fail++; $display("FAIL hold_door_wins: got %0d want 2", ifc.state); end
        step();
        step();
        ifc.expired = 1'b1;
        step();
        ifc.expired = 1'b0;
        n_checks++; if (ifc.state !== 3'd0) begin n_fail++; $display("FAIL hold_expire_state: got %0d want 0", ifc.state); end
        n_checks++; if (ifc.siren !== 1'b0 || ifc.status !== 1'b0) begin n_fail++; $display("FAIL hold_expire_out: got siren=%b status=%b want 0 0", ifc.siren, ifc.status); end
    endtask

    task automatic test_ignition_path();
        ifc.door_driver = 1'b1;
        step();
        ifc.door_driver = 1'b0;
        n_checks++; if (ifc.state !== 3'd1 || ifc.interval !== 2'd1) begin n_fail++; $display("FAIL dtrig: got state=%0d interval=%0d want 1 1", ifc.state, ifc.interval); end
        step();
        ifc.ignition = 1'b1;
        ifc.expired = 1'b1;
        step();
        ifc.ignition = 1'b0;
        ifc.expired = 1'b0;
        n_checks++; if (ifc.state !== 3'd4) begin n_fail++; $display("FAIL ign_priority: got %0d want 4", ifc.state); end
        n_checks++; if (ifc.status !== 1'b0 || ifc.siren !== 1'b0) begin n_fail++; $display("FAIL ign_out: got status=%b siren=%b want 0 0", ifc.status, ifc.siren); end
        step();
        n_checks++; if (ifc.state !== 3'd5) begin n_fail++; $display("FAIL ign_off: got %0d want 5", ifc.state); end
        ifc.door_pass = 1'b1;
        step();
        ifc.door_pass = 1'b0;
        n_checks++; if (ifc.state !== 3'd5) begin n_fail++; $display("FAIL wait_open_pass: got %0d want 5", ifc.state); end
        ifc.door_driver = 1'b1;
        step();
        ifc.door_driver = 1'b0;
        n_checks++; if (ifc.state !== 3'd6) begin n_fail++; $display("FAIL wait_open_drv: got %0d want 6", ifc.state); end
        step();
        n_checks++; if (ifc.state !== 3'd7 || ifc.interval !== 2'd0 || ifc.start_timer !== 1'b1) begin n_fail++; $display("FAIL arm_delay: got state=%0d interval=%0d start=%b want 7 0 1", ifc.state, ifc.interval, ifc.start_timer); end
        step();
        ifc.expired = 1'b1;
        step();
        ifc.expired = 1'b0;
        n_checks++; if (ifc.state !== 3'd0 || ifc.status !== 1'b0) begin n_fail++; $display("FAIL rearm: got state=%0d status=%b want 0 0", ifc.state, ifc.status); end
    endtask

    task automatic test_arm_delay_reopen();
        ifc.ignition = 1'b1;
        step();
        ifc.ignition = 1'b0;
        step();
        ifc.door_driver = 1'b1;
        step();
        ifc.door_driver = 1'b0;
        step();
        n_checks++; if (ifc.state !== 3'd7) begin n_fail++; $display("FAIL reopen_setup: got %0d want 7", ifc.state); end
        step();
        ifc.door_pass = 1'b1;
        step();
        ifc.door_pass = 1'b0;
        n_checks++; if (ifc.state !== 3'd6 || ifc.start_timer !== 1'b0) begin n_fail++; $display("FAIL reopen_state: got state=%0d start=%b want 6 0", ifc.state, ifc.start_timer); end
        step();
        n_checks++; if (ifc.state !== 3'd7 || ifc.start_timer !== 1'b1) begin n_fail++; $display("FAIL reopen_reload: got state=%0d start=%b want 7 1", ifc.state, ifc.start_timer); end
        step();
        ifc.door_pass = 1'b1;
        ifc.expired = 1'b1;
        step();
        ifc.door_pass = 1'b0;
        ifc.expired = 1'b0;
        n_checks++; if (ifc.state !== 3'd6) begin n_fail++; $display("FAIL delay_door_wins: got %0d want 6", ifc.state); end
        step();
        step();
        ifc.ignition = 1'b1;
        step();
        ifc.ignition = 1'b0;
        n_checks++; if (ifc.state !== 3'd4) begin n_fail++; $display("FAIL delay_ign: got %0d want 4", ifc.state); end
    endtask

    task automatic test_reset_mid_hold();
        reset = 1'b1;
        #1;
        reset = 1'b0;
        ifc.door_driver = 1'b1;
        step();
        ifc.door_driver = 1'b0;
        step();
        ifc.expired = 1'b1;
        step();
        ifc.expired = 1'b0;
        step();
        n_checks++; if (ifc.state !== 3'd3 || ifc.siren !== 1'b1 || ifc.start_timer !== 1'b1) begin n_fail++; $display("FAIL midrst_setup: got state=%0d siren=%b start=%b want 3 1 1", ifc.state, ifc.siren, ifc.start_timer); end
        #1;
        reset = 1'b1;
        #1;
        n_checks++; if (ifc.state !== 3'd0) begin n_fail++; $display("FAIL midrst_state: got %0d want 0", ifc.state); end
        n_checks++; if (ifc.siren !== 1'b0 || ifc.status !== 1'b0 || ifc.start_timer !== 1'b0) begin n_fail++; $display("FAIL midrst_out: got siren=%b status=%b start=%b want 0 0 0", ifc.siren, ifc.status, ifc.start_timer); end
        step();
        reset = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_fail = 0;
        reset = 1'b0;
        ifc.ignition = 1'b0;
        ifc.door_driver = 1'b0;
        ifc.door_pass = 1'b0;
        ifc.expired = 1'b0;
        ifc.half_hz_enable = 1'b0;
        #2;
        test_reset();
        test_armed_blink();
        test_passenger_trigger();
        test_alarm_hold();
        test_ignition_path();
        test_arm_delay_reopen();
        test_reset_mid_hold();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
